// File: rtl/alu_divider.sv
// Iterative radix-2 restoring divider for DIVU/DIV/REMU/REM.
// Runs one shift-subtract step per clock on operand magnitudes. A final FIX
// cycle applies the sign correction and selects the quotient or remainder.
// Divide-by-zero and signed overflow are decided when the request is
// accepted. They skip the iteration and spend two cycles in FIX.
//
// Handshake: a request is taken when start=1 on a rising edge while the
// unit is IDLE or DONE. busy is high in every cycle between acceptance and
// the result. start is ignored while busy=1. done is a one-cycle pulse, and
// result/div_by_zero/overflow are valid from that cycle. They hold until the
// next done pulse or reset; the two flags are also cleared when a new
// request is accepted.
module alu_divider #(
  parameter int WORDSIZE = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WORDSIZE-1:0] input_a,
  input  logic [WORDSIZE-1:0] input_b,
  input  logic [1:0]          operation,
  output logic                busy,
  output logic                done,
  output logic [WORDSIZE-1:0] result,
  output logic                div_by_zero,
  output logic                overflow,
  output logic [1:0]          dbg_state
);

  localparam int W  = WORDSIZE;
  localparam int CW = $clog2(WORDSIZE) + 1;

  localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WORDSIZE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Datapath registers
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  rem_q;     // partial remainder, always < divisor between steps
  logic [W-1:0]  quo_q;     // dividend shifting out, quotient shifting in
  logic [W-1:0]  dvs_q;     // divisor magnitude
  logic          op_rem_q;  // 1: deliver remainder, 0: deliver quotient
  logic          q_neg_q;
  logic          r_neg_q;
  logic          dz_pend_q;
  logic          ov_pend_q;

  // Output registers
  logic          busy_q;
  logic          done_q;
  logic [W-1:0]  result_q;
  logic          dz_q;
  logic          ov_q;

  // Request decode, used only on the accepting edge
  logic          accept;
  logic          is_signed;
  logic          b_zero;
  logic          ovf_case;
  logic [W-1:0]  a_abs;
  logic [W-1:0]  b_abs;

  // One restoring step: the shifted remainder is W+1 bits wide
  logic [W:0]    rem_shift;
  logic          step_ge;
  logic [W-1:0]  step_diff;

  // Sign-corrected results for the FIX cycle
  logic [W-1:0]  quo_fix;
  logic [W-1:0]  rem_fix;

  // Operand classification and magnitudes of the incoming request
  always_comb begin
    is_signed = operation[0];
    b_zero    = (input_b == '0);
    ovf_case  = is_signed && (input_a == MIN_NEG) && (input_b == '1);
    a_abs     = (is_signed && input_a[W-1]) ? (~input_a + 1'b1) : input_a;
    b_abs     = (is_signed && input_b[W-1]) ? (~input_b + 1'b1) : input_b;
  end

  // Shift-subtract step and final sign correction
  always_comb begin
    rem_shift = {rem_q, quo_q[W-1]};
    step_ge   = (rem_shift >= {1'b0, dvs_q});
    // Only used when step_ge=1, so the true difference fits in W bits.
    step_diff = rem_shift[W-1:0] - dvs_q;
    quo_fix   = q_neg_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix   = r_neg_q ? (~rem_q + 1'b1) : rem_q;
  end

  // Next-state logic for the control FSM
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (b_zero || ovf_case) ? S_FIX : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_ONE) state_d = S_FIX;
      end
      S_FIX: begin
        // The counter is left at 1 by the special-case bypass, giving one extra FIX cycle.
        if (cnt_q == CNT_ZERO) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Registered busy/done flags, derived from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d == S_RUN) || (state_d == S_FIX);
      done_q <= (state_d == S_DONE);
    end
  end

  // Operand latch, iteration and result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      op_rem_q  <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      dz_pend_q <= 1'b0;
      ov_pend_q <= 1'b0;
      result_q  <= '0;
      dz_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else if (accept) begin
      dz_q     <= 1'b0;
      ov_q     <= 1'b0;
      op_rem_q <= operation[1];
      dvs_q    <= b_abs;
      if (b_zero) begin
        // Quotient all ones, remainder is the raw dividend, no sign fixup.
        quo_q     <= '1;
        rem_q     <= input_a;
        q_neg_q   <= 1'b0;
        r_neg_q   <= 1'b0;
        dz_pend_q <= 1'b1;
        ov_pend_q <= 1'b0;
        cnt_q     <= CNT_ONE;
      end else if (ovf_case) begin
        // Most negative value divided by -1: quotient wraps to the dividend.
        quo_q     <= input_a;
        rem_q     <= '0;
        q_neg_q   <= 1'b0;
        r_neg_q   <= 1'b0;
        dz_pend_q <= 1'b0;
        ov_pend_q <= 1'b1;
        cnt_q     <= CNT_ONE;
      end else begin
        quo_q     <= a_abs;
        rem_q     <= '0;
        q_neg_q   <= is_signed && (input_a[W-1] ^ input_b[W-1]);
        r_neg_q   <= is_signed && input_a[W-1];
        dz_pend_q <= 1'b0;
        ov_pend_q <= 1'b0;
        cnt_q     <= CNT_FULL;
      end
    end else begin
      case (state_q)
        S_RUN: begin
          quo_q <= {quo_q[W-2:0], step_ge};
          rem_q <= step_ge ? step_diff : rem_shift[W-1:0];
          cnt_q <= cnt_q - CNT_ONE;
        end
        S_FIX: begin
          if (cnt_q != CNT_ZERO) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else begin
            result_q <= op_rem_q ? rem_fix : quo_fix;
            dz_q     <= dz_pend_q;
            ov_q     <= ov_pend_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign div_by_zero = dz_q;
  assign overflow    = ov_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_divider.sv
// Directed testbench for alu_divider (WORDSIZE=64).
module tb_alu_divider;

  localparam int W = 64;
  localparam logic [1:0] OP_DIVU = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;
  localparam logic [1:0] OP_REM  = 2'b11;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] input_a;
  logic [W-1:0] input_b;
  logic [1:0]   operation;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         div_by_zero;
  logic         overflow;
  logic [1:0]   dbg_state;

  int errors = 0;
  int checks = 0;

  alu_divider #(.WORDSIZE(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .input_a     (input_a),
    .input_b     (input_b),
    .operation   (operation),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .dbg_state   (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present a request and hold start through one rising edge (E0).
  // Operands are scrambled afterwards because they are don't-care once accepted.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    @(negedge clk);
    input_a   = a;
    input_b   = b;
    operation = op;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    input_a   = {$urandom, $urandom};
    input_b   = {$urandom, $urandom};
    operation = 2'($urandom_range(0, 3));
  endtask

  // Bounded wait for done; n counts edges after E0, continuing from n0.
  task automatic wait_done(input int n0, input int max_n, output int n, output bit got);
    n   = n0;
    got = 1'b0;
    while (!got && n < max_n) begin
      @(posedge clk);
      #1;
      n++;
      if (done) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    input_a = '0;
    input_b = '0;
    operation = OP_DIVU;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b expected 0", div_by_zero); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ov: got %b expected 0", overflow); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_divu();
    int n;
    bit got;
    issue(64'd100, 64'd7, OP_DIVU);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL divu_busy_start: got %b expected 1", busy); end
    wait_done(0, 200, n, got);
    checks++; if (!got || n != 65) begin errors++; $display("FAIL divu_latency: got %0d (seen %0d) expected 65", n, got); end
    checks++; if (result !== 64'd14) begin errors++; $display("FAIL divu_result: got %h expected %h", result, 64'd14); end
    checks++; if (div_by_zero !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL divu_flags: got dz=%b ov=%b expected 0 0", div_by_zero, overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divu_busy_done: got %b expected 0", busy); end
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL divu_done_pulse: got %b expected 0", done); end
    checks++; if (result !== 64'd14) begin errors++; $display("FAIL divu_result_hold: got %h expected %h", result, 64'd14); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL divu_idle: got %0d expected 0", dbg_state); end
    // Large unsigned dividend
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, OP_DIVU);
    wait_done(0, 200, n, got);
    checks++; if (!got || result !== 64'h7FFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL divu_large: got %h expected 7fffffffffffffff", result); end
    issue(64'd1000, 64'd33, OP_REMU);
    wait_done(0, 200, n, got);
    checks++; if (!got || result !== 64'd10) begin errors++; $display("FAIL remu_basic: got %h expected %h", result, 64'd10); end
  endtask

  task automatic test_signed();
    int n;
    bit got;
    issue(-64'sd100, 64'd7, OP_REM);
    wait_done(0, 200, n, got);
    checks++; if (!got || n != 65) begin errors++; $display("FAIL rem_latency: got %0d expected 65", n); end
    checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL rem_neg: got %h expected fffffffffffffffe", result); end
    issue(-64'sd100, 64'd7, OP_DIV);
    wait_done(0, 200, n, got);
    checks++; if (!got || result !== 64'hFFFF_FFFF_FFFF_FFF2) begin errors++; $display("FAIL div_neg: got %h expected fffffffffffffff2", result); end
    issue(64'd100, -64'sd7, OP_DIV);
    wait_done(0, 200, n, got);
    checks++; if (!got || result !== 64'hFFFF_FFFF_FFFF_FFF2) begin errors++; $display("FAIL div_negb: got %h expected fffffffffffffff2", result); end
    issue(64'd100, -64'sd7, OP_REM);
    wait_done(0, 200, n, got);
    checks++; if (!got || result !== 64'd2) begin errors++; $display("FAIL rem_negb: got %h expected %h", result, 64'd2); end
    issue(-64'sd100, -64'sd7, OP_DIV);
    wait_done(0, 200, n, got);
    checks++; if (!got || result !== 64'd14) begin errors++; $display("FAIL div_negab: got %h expected %h", result, 64'd14); end
  endtask

  task automatic test_div_zero();
    int n;
    bit got;
    issue(64'd5, 64'd0, OP_DIVU);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dz_busy: got %b expected 1", busy); end
    wait_done(0, 20, n, got);
    checks++; if (!got || n != 2) begin errors++; $display("FAIL dz_latency: got %0d (seen %0d) expected 2", n, got); end
    checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL dz_divu: got %h expected ffffffffffffffff", result); end
    checks++; if (div_by_zero !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL dz_flags: got dz=%b ov=%b expected 1 0", div_by_zero, overflow); end
    issue(64'd5, 64'd0, OP_REMU);
    wait_done(0, 20, n, got);
    checks++; if (!got || result !== 64'd5) begin errors++; $display("FAIL dz_remu: got %h expected %h", result, 64'd5); end
    issue(-64'sd5, 64'd0, OP_REM);
    wait_done(0, 20, n, got);
    checks++; if (!got || result !== 64'hFFFF_FFFF_FFFF_FFFB || div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_rem: got %h dz=%b expected fffffffffffffffb dz=1", result, div_by_zero); end
    issue(-64'sd5, 64'd0, OP_DIV);
    wait_done(0, 20, n, got);
    checks++; if (!got || result !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL dz_div: got %h expected ffffffffffffffff", result); end
  endtask

  task automatic test_overflow();
    int n;
    bit got;
    issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, OP_DIV);
    wait_done(0, 20, n, got);
    checks++; if (!got || n != 2) begin errors++; $display("FAIL ov_latency: got %0d expected 2", n); end
    checks++; if (result !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL ov_div: got %h expected 8000000000000000", result); end
    checks++; if (overflow !== 1'b1 || div_by_zero !== 1'b0) begin errors++; $display("FAIL ov_flags: got ov=%b dz=%b expected 1 0", overflow, div_by_zero); end
    issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, OP_REM);
    wait_done(0, 20, n, got);
    checks++; if (!got || result !== 64'h0 || overflow !== 1'b1) begin errors++; $display("FAIL ov_rem: got %h ov=%b expected 0 ov=1", result, overflow); end
    // Same bit patterns unsigned: an ordinary division giving 0
    issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, OP_DIVU);
    wait_done(0, 200, n, got);
    checks++; if (!got || n != 65 || result !== 64'h0 || overflow !== 1'b0) begin errors++; $display("FAIL ov_divu: got %h ov=%b n=%0d expected 0 ov=0 n=65", result, overflow, n); end
  endtask

  task automatic test_busy_ignore();
    int n;
    bit got;
    issue(64'd100, 64'd7, OP_DIVU);
    repeat (9) @(posedge clk);
    @(negedge clk);
    input_a   = 64'd9;
    input_b   = 64'd3;
    operation = OP_DIVU;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy: got %b expected 1", busy); end
    wait_done(10, 200, n, got);
    checks++; if (!got || n != 65) begin errors++; $display("FAIL ignore_latency: got %0d expected 65", n); end
    checks++; if (result !== 64'd14) begin errors++; $display("FAIL ignore_result: got %h expected %h", result, 64'd14); end
  endtask

  task automatic test_back_to_back();
    int n;
    bit got;
    issue(64'd5, 64'd0, OP_DIVU);
    wait_done(0, 20, n, got);
    checks++; if (!got || div_by_zero !== 1'b1) begin errors++; $display("FAIL b2b_first: got dz=%b expected 1", div_by_zero); end
    // Start again during the done cycle
    issue(64'd9, 64'd3, OP_DIVU);
    checks++; if (busy !== 1'b1 || dbg_state !== 2'd1) begin errors++; $display("FAIL b2b_accept: got busy=%b state=%0d expected 1 1", busy, dbg_state); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL b2b_dz_clear: got %b expected 0", div_by_zero); end
    checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL b2b_result_hold: got %h expected ffffffffffffffff", result); end
    wait_done(0, 200, n, got);
    checks++; if (!got || n != 65 || result !== 64'd3) begin errors++; $display("FAIL b2b_second: got %h n=%0d expected 3 n=65", result, n); end
  endtask

  task automatic test_reset_mid();
    int n;
    bit got;
    int dones;
    issue(64'd100, 64'd7, OP_DIVU);
    repeat (19) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: got busy=%b done=%b expected 0 0", busy, done); end
    checks++; if (result !== 64'h0 || div_by_zero !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_out: got %h dz=%b ov=%b expected 0", result, div_by_zero, overflow); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_mid_state: got %0d expected 0", dbg_state); end
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL rst_mid_nodone: got %0d expected 0", dones); end
    issue(64'd9, 64'd3, OP_DIVU);
    wait_done(0, 200, n, got);
    checks++; if (!got || result !== 64'd3) begin errors++; $display("FAIL rst_mid_after: got %h expected %h", result, 64'd3); end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_div_zero();
    test_overflow();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
